// File: rtl/rs_bma_sched_pkg.sv
// Shared types for the BMA scheduler slice: RS symbol type, code sizes,
// scheduler FSM encodings and the all-zero-but-one locator constant.
package rs_bma_sched_pkg;

  localparam int SYM_W = 8;
  localparam int check = 4;
  localparam int errs  = check / 2;

  typedef logic [SYM_W-1:0] data_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  // Locator polynomial 1 + 0x + ... : reported when the engine hangs.
  localparam logic [(errs+1)*SYM_W-1:0] LOC_ONE =
    {data_t'(1), {(errs*SYM_W){1'b0}}};

endpackage

// File: rtl/rs_rr_arb.sv
// Round-robin picker: ireq/iadv in, ogrant_any/ogrant_idx out.
// Search starts at pointer rr; rr moves past the winner when iadv is high.
module rs_rr_arb #(
  parameter int pCH_NUM = 4
) (
  input  logic                       iclk,
  input  logic                       ireset,
  input  logic [pCH_NUM-1:0]         ireq,
  input  logic                       iadv,
  output logic                       ogrant_any,
  output logic [$clog2(pCH_NUM)-1:0] ogrant_idx
);

  localparam int CH_W = $clog2(pCH_NUM);

  logic [CH_W-1:0] rr;

  function automatic logic [CH_W-1:0] wrap(input int a);
    if (a >= pCH_NUM)
      return CH_W'(a - pCH_NUM);
    return CH_W'(a);
  endfunction

  // Walk from the farthest offset down so the
  // closest pending channel to rr wins.
  always_comb begin
    ogrant_any = 1'b0;
    ogrant_idx = rr;
    for (int k = pCH_NUM - 1; k >= 0; k--) begin
      if (ireq[wrap(int'(rr) + k)]) begin
        ogrant_any = 1'b1;
        ogrant_idx = wrap(int'(rr) + k);
      end
    end
  end

  always_ff @(posedge iclk) begin
    if (ireset)
      rr <= '0;
    else if (iadv)
      rr <= wrap(int'(ogrant_idx) + 1);
  end

endmodule

// File: rtl/rs_bma_sched.sv
// Shares one BMA engine among pCH_NUM syndrome channels: holding regs,
// round-robin launch, tagged result return, watchdog and stray detect.
module rs_bma_sched
  import rs_bma_sched_pkg::*;
#(
  parameter int pCH_NUM  = 4,
  parameter int pTIMEOUT = 1023
) (
  input  logic                         iclk,
  input  logic                         ireset,
  input  logic [pCH_NUM-1:0]           isyndrome_val,
  input  data_t [pCH_NUM-1:0][1:check] isyndrome,
  output logic [pCH_NUM-1:0]           osyndrome_rdy,
  output logic                         obma_syndrome_val,
  output data_t [1:check]              obma_syndrome,
  input  logic                         ibma_loc_poly_val,
  input  data_t [0:errs]               ibma_loc_poly,
  input  data_t [1:errs]               ibma_omega_poly,
  input  data_t                        ibma_loc_poly_deg,
  input  logic                         ibma_loc_failed,
  output logic                         oloc_poly_val,
  output logic [$clog2(pCH_NUM)-1:0]   oloc_ch,
  output data_t [0:errs]               oloc_poly,
  output data_t [1:errs]               oomega_poly,
  output data_t                        oloc_poly_deg,
  output logic                         oloc_failed,
  output logic                         otimeout,
  output logic                         ostray
);

  localparam int CH_W  = $clog2(pCH_NUM);
  localparam int CNT_W = $clog2(pTIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(pTIMEOUT);

  logic [1:0]         state;
  logic [pCH_NUM-1:0] pend;
  logic [pCH_NUM-1:0] load;
  logic [pCH_NUM-1:0] take;
  data_t [1:check]    hold [pCH_NUM];
  logic [CH_W-1:0]    tag;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic               gnt_any;
  logic [CH_W-1:0]    gnt_idx;
  logic               grant;
  logic               expire;

  rs_rr_arb #(
    .pCH_NUM (pCH_NUM)
  ) u_arb (
    .iclk       (iclk),
    .ireset     (ireset),
    .ireq       (pend),
    .iadv       (grant),
    .ogrant_any (gnt_any),
    .ogrant_idx (gnt_idx)
  );

  assign grant = (state == ST_IDLE) && gnt_any;
  assign load  = isyndrome_val & ~pend;

  always_comb begin
    take = '0;
    if (grant)
      take[gnt_idx] = 1'b1;
  end

  assign osyndrome_rdy     = ~pend;
  assign obma_syndrome_val = (state == ST_ISSUE);

  // Saturating count; expiry is judged on the
  // value the counter is about to take.
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
  assign expire  = (cnt_inc >= TMO);

  always_ff @(posedge iclk) begin
    if (ireset) begin
      state         <= ST_IDLE;
      pend          <= '0;
      tag           <= '0;
      cnt           <= '0;
      obma_syndrome <= '0;
      oloc_poly_val <= 1'b0;
      oloc_ch       <= '0;
      oloc_poly     <= '0;
      oomega_poly   <= '0;
      oloc_poly_deg <= '0;
      oloc_failed   <= 1'b0;
      otimeout      <= 1'b0;
      ostray        <= 1'b0;
      for (int i = 0; i < pCH_NUM; i++)
        hold[i] <= '0;
    end else begin
      oloc_poly_val <= 1'b0;
      otimeout      <= 1'b0;
      ostray        <= 1'b0;
      pend          <= (pend & ~take) | load;
      for (int i = 0; i < pCH_NUM; i++)
        if (load[i])
          hold[i] <= isyndrome[i];

      unique case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            obma_syndrome <= hold[gnt_idx];
            tag           <= gnt_idx;
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ibma_loc_poly_val) begin
            oloc_poly_val <= 1'b1;
            oloc_ch       <= tag;
            oloc_poly     <= ibma_loc_poly;
            oomega_poly   <= ibma_omega_poly;
            oloc_poly_deg <= ibma_loc_poly_deg;
            oloc_failed   <= ibma_loc_failed;
            state         <= ST_IDLE;
          end else if (expire) begin
            oloc_poly_val <= 1'b1;
            oloc_ch       <= tag;
            oloc_poly     <= LOC_ONE;
            oomega_poly   <= '0;
            oloc_poly_deg <= '0;
            oloc_failed   <= 1'b1;
            otimeout      <= 1'b1;
            state         <= ST_IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (ibma_loc_poly_val && (state != ST_WAIT))
        ostray <= 1'b1;
    end
  end

endmodule
